// File: rtl/vf_pkg.sv
// Shared definitions for the vector feeder.
//   DW      : default element width in bits
//   DEPTH   : default entries per vector buffer (power of two)
//   TIMEOUT : edges allowed for the downstream busy handshake
//   vf_state_e : feeder state encoding
package vf_pkg;

  localparam int DW      = 8;
  localparam int DEPTH   = 8;
  localparam int TIMEOUT = 16;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    WAIT_BUSY = 3'd2,
    STREAM    = 3'd3,
    DRAIN     = 3'd4,
    FINISH    = 3'd5
  } vf_state_e;

endpackage

// File: rtl/vf_buffer.sv
// Two DEPTH x DW vector banks (A and B) with one write port and one shared
// combinational read index. The contents have no reset.
//   clock  : rising-edge clock
//   we     : write enable (already qualified by the caller)
//   sel    : bank select for writes, 0 = A, 1 = B
//   waddr  : write index
//   wdata  : write data
//   raddr  : shared read index for both banks
//   rd_a   : A[raddr]
//   rd_b   : B[raddr]
module vf_buffer #(
  parameter int DW    = vf_pkg::DW,
  parameter int DEPTH = vf_pkg::DEPTH
) (
  input  logic                     clock,
  input  logic                     we,
  input  logic                     sel,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [DW-1:0]            wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [DW-1:0]            rd_a,
  output logic [DW-1:0]            rd_b
);

  logic [DW-1:0] mem_a_q [DEPTH];
  logic [DW-1:0] mem_b_q [DEPTH];

  always_ff @(posedge clock) begin
    if (we) begin
      if (sel) mem_b_q[waddr] <= wdata;
      else     mem_a_q[waddr] <= wdata;
    end
  end

  assign rd_a = mem_a_q[raddr];
  assign rd_b = mem_b_q[raddr];

endmodule

// File: rtl/vector_feeder.sv
// Streams two buffered vectors element-pairwise to a downstream dot-product
// stage, with a start pulse, busy handshake and handshake timeouts.
//   clock, reset : clock and synchronous active-low reset
//   wr_en/wr_sel/wr_addr/wr_data : buffer write port (honoured in IDLE only)
//   len, go      : element count (1..DEPTH) sampled with the go strobe
//   dp_start     : one-cycle start pulse to downstream
//   dp_a, dp_b, dp_valid : element beats, zero when not valid
//   dp_busy      : downstream busy flag
//   busy, done, error : status (done/error are one-cycle pulses)
//
// state     | meaning
// ----------+------------------------------------------------------
// IDLE      | accepting writes and go
// START     | dp_start asserted for this single cycle
// WAIT_BUSY | waiting for downstream to raise dp_busy (timed)
// STREAM    | one beat per cycle, index 0..len-1
// DRAIN     | waiting for downstream to drop dp_busy (timed)
// FINISH    | done pulse, back to IDLE
module vector_feeder #(
  parameter int DW    = vf_pkg::DW,
  parameter int DEPTH = vf_pkg::DEPTH
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     wr_en,
  input  logic                     wr_sel,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [DW-1:0]            wr_data,
  input  logic [$clog2(DEPTH):0]   len,
  input  logic                     go,
  output logic                     dp_start,
  output logic [DW-1:0]            dp_a,
  output logic [DW-1:0]            dp_b,
  output logic                     dp_valid,
  input  logic                     dp_busy,
  output logic                     busy,
  output logic                     done,
  output logic                     error
);

  import vf_pkg::*;

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int TW = $clog2(TIMEOUT);
  localparam logic [TW-1:0] TMO_LOAD = TW'(TIMEOUT - 1);
  localparam logic [LW-1:0] LEN_MAX  = LW'(DEPTH);

  vf_state_e     state_q, state_d;
  logic [LW-1:0] len_q, len_d;
  logic [LW-1:0] idx_q, idx_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          dp_start_q, dp_start_d;
  logic          dp_valid_q, dp_valid_d;
  logic [DW-1:0] dp_a_q, dp_a_d;
  logic [DW-1:0] dp_b_q, dp_b_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          error_q, error_d;

  logic          buf_we;
  logic [DW-1:0] rd_a, rd_b;

  // Writes are honoured only in IDLE and never on a reset edge.
  assign buf_we = wr_en & reset & (state_q == IDLE);

  vf_buffer #(.DW(DW), .DEPTH(DEPTH)) u_buffer (
    .clock (clock),
    .we    (buf_we),
    .sel   (wr_sel),
    .waddr (wr_addr),
    .wdata (wr_data),
    .raddr (idx_q[AW-1:0]),
    .rd_a  (rd_a),
    .rd_b  (rd_b)
  );

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    idx_d   = idx_q;
    tmo_d   = tmo_q;
    error_d = 1'b0;

    case (state_q)
      IDLE: begin
        idx_d = '0;
        if (go) begin
          if ((len != '0) && (len <= LEN_MAX)) begin
            len_d   = len;
            state_d = START;
          end else begin
            error_d = 1'b1;
          end
        end
      end
      START: begin
        tmo_d   = TMO_LOAD;
        state_d = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (dp_busy) begin
          state_d = STREAM;
        end else if (tmo_q == '0) begin
          error_d = 1'b1;
          state_d = IDLE;
        end else begin
          tmo_d = tmo_q - TW'(1);
        end
      end
      STREAM: begin
        // Index is one bit wider than the address so it never wraps.
        idx_d = idx_q + LW'(1);
        if (idx_q == len_q - LW'(1)) begin
          tmo_d   = TMO_LOAD;
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (!dp_busy) begin
          state_d = FINISH;
        end else if (tmo_q == '0) begin
          error_d = 1'b1;
          state_d = IDLE;
        end else begin
          tmo_d = tmo_q - TW'(1);
        end
      end
      FINISH: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    dp_start_d = (state_d == START);
    busy_d     = (state_d != IDLE);
    done_d     = (state_d == FINISH);
    // Beats trail the STREAM state by one registered stage.
    dp_valid_d = (state_q == STREAM);
    dp_a_d     = dp_valid_d ? rd_a : '0;
    dp_b_d     = dp_valid_d ? rd_b : '0;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q    <= IDLE;
      len_q      <= '0;
      idx_q      <= '0;
      tmo_q      <= '0;
      dp_start_q <= 1'b0;
      dp_valid_q <= 1'b0;
      dp_a_q     <= '0;
      dp_b_q     <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      idx_q      <= idx_d;
      tmo_q      <= tmo_d;
      dp_start_q <= dp_start_d;
      dp_valid_q <= dp_valid_d;
      dp_a_q     <= dp_a_d;
      dp_b_q     <= dp_b_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      error_q    <= error_d;
    end
  end

  assign dp_start = dp_start_q;
  assign dp_valid = dp_valid_q;
  assign dp_a     = dp_a_q;
  assign dp_b     = dp_b_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign error    = error_q;

endmodule

// File: tb/tb_vector_feeder.sv
// Bench for vector_feeder. Each transfer is planned up front as a timeline of
// expected outputs indexed by clock edge; a single compare process checks the
// DUT against that timeline after every edge.
module tb_vector_feeder;

  localparam int NE = 1024;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       wr_en = 1'b0;
  logic       wr_sel = 1'b0;
  logic [2:0] wr_addr = '0;
  logic [7:0] wr_data = '0;
  logic [3:0] len = '0;
  logic       go = 1'b0;
  logic       dp_busy = 1'b0;
  logic       dp_start, dp_valid, busy, done, error;
  logic [7:0] dp_a, dp_b;

  int edge_n   = 0;
  int n_checks = 0;
  int n_fail   = 0;
  bit check_en = 1'b0;

  bit         exp_start [NE];
  bit         exp_valid [NE];
  bit         exp_busy  [NE];
  bit         exp_done  [NE];
  bit         exp_error [NE];
  logic [7:0] exp_a     [NE];
  logic [7:0] exp_b     [NE];
  bit         busy_plan [NE];
  logic [7:0] ma [8];
  logic [7:0] mb [8];

  vector_feeder #(.DW(8), .DEPTH(8)) dut (
    .clock    (clock),
    .reset    (reset),
    .wr_en    (wr_en),
    .wr_sel   (wr_sel),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .len      (len),
    .go       (go),
    .dp_start (dp_start),
    .dp_a     (dp_a),
    .dp_b     (dp_b),
    .dp_valid (dp_valid),
    .dp_busy  (dp_busy),
    .busy     (busy),
    .done     (done),
    .error    (error)
  );

  always #5 clock = ~clock;

  // edge_n == k means edge k is the most recent rising edge.
  always @(posedge clock) edge_n <= edge_n + 1;

  // Downstream model: dp_busy level for the next edge comes from the plan.
  always @(posedge clock) begin
    #2;
    dp_busy = (edge_n + 1 < NE) ? busy_plan[edge_n + 1] : 1'b0;
  end

  task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at edge %0d: got %0h, expected %0h", name, k, act, exp);
    end
  endtask

  always @(negedge clock) begin
    int k;
    if (check_en) begin
      k = edge_n;
      chk("dp_start", k, 32'(dp_start), 32'(exp_start[k]));
      chk("dp_valid", k, 32'(dp_valid), 32'(exp_valid[k]));
      chk("dp_a",     k, 32'(dp_a),     32'(exp_a[k]));
      chk("dp_b",     k, 32'(dp_b),     32'(exp_b[k]));
      chk("busy",     k, 32'(busy),     32'(exp_busy[k]));
      chk("done",     k, 32'(done),     32'(exp_done[k]));
      chk("error",    k, 32'(error),    32'(exp_error[k]));
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_until(input int e);
    while (edge_n < e) tick();
  endtask

  // Expected timeline of one go issued at edge g. r: edge where dp_busy is
  // first sampled high (-1: never). f: edge where it is sampled low again
  // (-1: never). Returns the edge after which the feeder is idle again.
  task automatic plan(input int g, input int L, input int r, input int f, output int fin);
    int d0, d, hi_end;
    if (L < 1 || L > 8) begin
      exp_error[g] = 1'b1;
      fin = g;
      return;
    end
    exp_start[g] = 1'b1;
    if (r < 0) begin
      for (int e = g; e <= g + 16; e++) exp_busy[e] = 1'b1;
      exp_error[g + 17] = 1'b1;
      fin = g + 17;
      return;
    end
    d0 = r + L + 1;
    hi_end = (f < 0) ? d0 + 20 : f;
    for (int e = r; e < hi_end; e++) busy_plan[e] = 1'b1;
    for (int i = 0; i < L; i++) begin
      exp_valid[r + 1 + i] = 1'b1;
      exp_a[r + 1 + i]     = ma[i];
      exp_b[r + 1 + i]     = mb[i];
    end
    d = (f > d0) ? f : d0;
    if (f >= 0 && (d - d0) < 16) begin
      for (int e = g; e <= d; e++) exp_busy[e] = 1'b1;
      exp_done[d] = 1'b1;
      fin = d + 1;
    end else begin
      for (int e = g; e <= d0 + 14; e++) exp_busy[e] = 1'b1;
      exp_error[d0 + 15] = 1'b1;
      fin = d0 + 15;
    end
  endtask

  task automatic do_write(input logic sel, input int addr, input logic [7:0] data, input bit model_upd);
    wr_en   = 1'b1;
    wr_sel  = sel;
    wr_addr = 3'(addr);
    wr_data = data;
    if (model_upd) begin
      if (sel) mb[addr] = data;
      else     ma[addr] = data;
    end
    tick();
    wr_en = 1'b0;
  endtask

  // rd/fd are offsets from the go edge (-1: never).
  task automatic do_go(input int L, input int rd, input int fd, output int g, output int fin);
    int r, f;
    g = edge_n + 1;
    r = (rd < 0) ? -1 : g + rd;
    f = (fd < 0) ? -1 : g + fd;
    go  = 1'b1;
    len = 4'(L);
    plan(g, L, r, f, fin);
    tick();
    go    = 1'b0;
    len   = '0;
    wr_en = 1'b0;
  endtask

  initial begin
    int g, fin;
    for (int e = 0; e < NE; e++) begin
      exp_a[e] = '0;
      exp_b[e] = '0;
    end

    reset = 1'b0;
    tick();
    check_en = 1'b1;
    tick();
    reset = 1'b1;

    for (int i = 0; i < 8; i++) begin
      do_write(1'b0, i, 8'((i < 4) ? i + 1 : i + 5), 1'b1);
      do_write(1'b1, i, 8'((i < 4) ? i + 5 : i + 9), 1'b1);
    end
    tick();

    // Basic stream, busy rises the cycle after dp_start.
    do_go(4, 2, 9, g, fin);
    chk("pin_basic_no_early_valid", g + 2, 32'(exp_valid[g + 2]), 32'd0);
    chk("pin_basic_a0", g + 3, 32'(exp_a[g + 3]), 32'd1);
    chk("pin_basic_b0", g + 3, 32'(exp_b[g + 3]), 32'd5);
    chk("pin_basic_a3", g + 6, 32'(exp_a[g + 6]), 32'd4);
    chk("pin_basic_b3", g + 6, 32'(exp_b[g + 6]), 32'd8);
    chk("pin_basic_no_beat5", g + 7, 32'(exp_valid[g + 7]), 32'd0);
    chk("pin_basic_done", g + 9, 32'(exp_done[g + 9]), 32'd1);
    chk("pin_basic_idle", g + 10, 32'(exp_busy[g + 10]), 32'd0);
    wait_until(fin + 25);

    // Rejected lengths.
    do_go(0, -1, -1, g, fin);
    chk("pin_len0_error", g, 32'(exp_error[g]), 32'd1);
    chk("pin_len0_nostart", g, 32'(exp_start[g]), 32'd0);
    wait_until(fin + 3);
    do_go(9, -1, -1, g, fin);
    chk("pin_len9_error", g, 32'(exp_error[g]), 32'd1);
    wait_until(fin + 3);

    // WAIT_BUSY timeout.
    do_go(4, -1, -1, g, fin);
    chk("pin_tmo_error", g + 17, 32'(exp_error[g + 17]), 32'd1);
    chk("pin_tmo_not_early", g + 16, 32'(exp_error[g + 16]), 32'd0);
    chk("pin_tmo_busy_last", g + 16, 32'(exp_busy[g + 16]), 32'd1);
    chk("pin_tmo_busy_off", g + 17, 32'(exp_busy[g + 17]), 32'd0);
    wait_until(fin + 25);

    // Busy rises on the 16th WAIT_BUSY edge: still accepted.
    do_go(2, 17, 25, g, fin);
    chk("pin_late_a0", g + 18, 32'(exp_a[g + 18]), 32'd1);
    chk("pin_late_done", g + 25, 32'(exp_done[g + 25]), 32'd1);
    wait_until(fin + 25);

    // Reset on beat 2 of a len=8 stream.
    do_go(8, 2, 30, g, fin);
    chk("pin_rst_beat1", g + 4, 32'(exp_valid[g + 4]), 32'd1);
    wait_until(g + 4);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    for (int e = g + 5; e < NE; e++) begin
      exp_start[e] = 1'b0; exp_valid[e] = 1'b0; exp_busy[e] = 1'b0;
      exp_done[e]  = 1'b0; exp_error[e] = 1'b0; busy_plan[e] = 1'b0;
      exp_a[e] = '0; exp_b[e] = '0;
    end
    wait_until(g + 10);

    // Full depth after reset: original contents, indices 0..7.
    do_go(8, 2, 14, g, fin);
    chk("pin_full_a0", g + 3, 32'(exp_a[g + 3]), 32'd1);
    chk("pin_full_a7", g + 10, 32'(exp_a[g + 10]), 32'd12);
    chk("pin_full_b7", g + 10, 32'(exp_b[g + 10]), 32'd16);
    chk("pin_full_no_wrap", g + 11, 32'(exp_valid[g + 11]), 32'd0);
    chk("pin_full_done", g + 14, 32'(exp_done[g + 14]), 32'd1);
    wait_until(fin + 25);

    // Write and go on the same edge, then writes during STREAM.
    wr_en = 1'b1; wr_sel = 1'b0; wr_addr = 3'd0; wr_data = 8'hFF;
    ma[0] = 8'hFF;
    do_go(4, 2, 9, g, fin);
    chk("pin_wrgo_a0", g + 3, 32'(exp_a[g + 3]), 32'hFF);
    wait_until(g + 4);
    do_write(1'b0, 1, 8'hAA, 1'b0);
    do_write(1'b1, 2, 8'hBB, 1'b0);
    wait_until(fin + 25);
    do_go(4, 2, 9, g, fin);
    chk("pin_keep_a1", g + 4, 32'(exp_a[g + 4]), 32'd2);
    chk("pin_keep_b2", g + 5, 32'(exp_b[g + 5]), 32'd7);
    wait_until(fin + 25);

    // Busy drops mid-stream: DRAIN completes immediately.
    do_go(8, 2, 5, g, fin);
    chk("pin_drain_fast_done", g + 11, 32'(exp_done[g + 11]), 32'd1);
    wait_until(fin + 25);

    // len=1 with busy never dropping: DRAIN timeout.
    do_go(1, 2, -1, g, fin);
    chk("pin_len1_beat", g + 3, 32'(exp_valid[g + 3]), 32'd1);
    chk("pin_len1_single", g + 4, 32'(exp_valid[g + 4]), 32'd0);
    chk("pin_drain_tmo", g + 19, 32'(exp_error[g + 19]), 32'd1);
    wait_until(fin + 25);

    tick();
    check_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
